if_stage_nw: RTL and testbench

IF_STAGE_NW -- requirements
Module: if_stage_nw

---
 rtl/if_stage_nw.sv | 142 ++++++++++++++
 tb/tb_if_stage_nw.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_nw.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_stage_nw
//  Purpose  : Instruction-fetch stage. It fetches 64-bit instruction lines,
//             buffers {IR,PC} pairs in a circular queue, and presents up to
//             FETCH_WIDTH in-order lanes to dispatch.
//  Ports    : clock, reset (async, active-low)
//             Imem2proc_data/valid     - instruction line from memory
//             dispatch_num_in          - lanes consumed this cycle
//             redirect_en_in/pc_in     - flush and redirect fetch
//             proc2Imem_addr           - line address of the fetch PC
//             if_IR_out/if_PC_out      - per-lane instruction and PC
//             if_valid_out/if_count_out- lane valids, queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage_nw #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          BUF_DEPTH   = 8,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [63:0]               Imem2proc_data,
    input  logic                      Imem2proc_valid,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] dispatch_num_in,
    input  logic                      redirect_en_in,
    input  logic [63:0]               redirect_pc_in,
    output logic [63:0]               proc2Imem_addr,
    output logic [32*FETCH_WIDTH-1:0] if_IR_out,
    output logic [64*FETCH_WIDTH-1:0] if_PC_out,
    output logic [FETCH_WIDTH-1:0]    if_valid_out,
    output logic [$clog2(BUF_DEPTH+1)-1:0] if_count_out
);

    localparam int CW = $clog2(FETCH_WIDTH+1);
    localparam int QW = $clog2(BUF_DEPTH+1);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [QW-1:0] c_depth = QW'(BUF_DEPTH);
    localparam logic [QW-1:0] c_fw    = QW'(FETCH_WIDTH);

    // Architectural state
    logic [63:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [QW-1:0] r_count;

    // Queue storage; never read unless count marks the entry live, so it
    // carries no reset.
    logic [31:0]   r_ir_mem [BUF_DEPTH];
    logic [63:0]   r_pc_mem [BUF_DEPTH];

    // Next-state and control
    logic [63:0]   w_pc_nxt;
    logic [AW-1:0] w_head_nxt;
    logic [AW-1:0] w_tail_nxt;
    logic [QW-1:0] w_count_nxt;
    logic [QW-1:0] w_n_push;
    logic [QW-1:0] w_free;
    logic [QW-1:0] w_pop;
    logic          w_push;
    logic          w_wr1_en;
    logic [31:0]   w_wr0_ir;
    logic [AW-1:0] w_tail_p1;

    always_comb begin
        // An unaligned PC (bit 2 set) only has the upper word left in its line.
        w_n_push = r_pc[2] ? QW'(1) : QW'(2);
        w_free   = c_depth - r_count;
        // Space is judged on the pre-pop count, so a full queue stalls even
        // when dispatch drains entries in the same cycle.
        w_push   = Imem2proc_valid && (w_free >= w_n_push) && !redirect_en_in;
        w_wr1_en = w_push && !r_pc[2];
        w_wr0_ir = r_pc[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];
        w_tail_p1 = r_tail + AW'(1);

        // Pop clamped to what is actually present and to the lane count.
        w_pop = QW'(dispatch_num_in);
        if (w_pop > r_count) w_pop = r_count;
        if (w_pop > c_fw)    w_pop = c_fw;

        w_pc_nxt    = r_pc;
        w_tail_nxt  = r_tail;
        w_head_nxt  = r_head + AW'(w_pop);
        w_count_nxt = r_count - w_pop;

        if (w_push) begin
            w_pc_nxt    = r_pc + {{(64-QW-2){1'b0}}, w_n_push, 2'b00};
            w_tail_nxt  = r_tail + AW'(w_n_push);
            w_count_nxt = r_count - w_pop + w_n_push;
        end

        if (redirect_en_in) begin
            w_pc_nxt    = redirect_pc_in & ~64'h3;
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_ir_mem[r_tail] <= w_wr0_ir;
            r_pc_mem[r_tail] <= r_pc;
        end
        if (w_wr1_en) begin
            r_ir_mem[w_tail_p1] <= Imem2proc_data[63:32];
            r_pc_mem[w_tail_p1] <= r_pc + 64'd4;
        end
    end

    assign proc2Imem_addr = r_pc & ~64'h7;
    assign if_count_out   = r_count;

    // Lane i shows the entry i places behind head, wrapping with the pointer.
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
        logic [AW-1:0] w_idx;
        logic          w_vld;
        assign w_idx = r_head + AW'(gi);
        assign w_vld = (r_count > QW'(gi));
        assign if_valid_out[gi]      = w_vld;
        assign if_IR_out[32*gi +: 32] = w_vld ? r_ir_mem[w_idx] : 32'h0;
        assign if_PC_out[64*gi +: 64] = w_vld ? r_pc_mem[w_idx] : 64'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_nw.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage_nw
//  Purpose  : Self-checking bench for if_stage_nw (FETCH_WIDTH=2, depth 8).
//             Table of vectors with hand-derived count/address, a reference
//             queue model as scoreboard for lane contents, random mixed
//             traffic across pointer wrap, and an asynchronous reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage_nw;

    logic         clock;
    logic         reset;
    logic [63:0]  Imem2proc_data;
    logic         Imem2proc_valid;
    logic [1:0]   dispatch_num_in;
    logic         redirect_en_in;
    logic [63:0]  redirect_pc_in;
    logic [63:0]  proc2Imem_addr;
    logic [63:0]  if_IR_out;
    logic [127:0] if_PC_out;
    logic [1:0]   if_valid_out;
    logic [3:0]   if_count_out;

    if_stage_nw #(.FETCH_WIDTH(2), .BUF_DEPTH(8), .RESET_PC(64'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .Imem2proc_data  (Imem2proc_data),
        .Imem2proc_valid (Imem2proc_valid),
        .dispatch_num_in (dispatch_num_in),
        .redirect_en_in  (redirect_en_in),
        .redirect_pc_in  (redirect_pc_in),
        .proc2Imem_addr  (proc2Imem_addr),
        .if_IR_out       (if_IR_out),
        .if_PC_out       (if_PC_out),
        .if_valid_out    (if_valid_out),
        .if_count_out    (if_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [63:0] data;      // 0 = derive from the current line address
        logic [1:0]  disp;
        logic        redir;
        logic [63:0] rpc;
        int          exp_count;
        logic [63:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
    } ent_t;

    vec_t        vecs [14];
    ent_t        m_q [$];
    logic [63:0] m_pc;
    logic [63:0] last_pop;
    bit          have_last;
    bit          seq_chk;
    int          n_checks;
    int          n_fail;

    function automatic logic [63:0] mkdata(input logic [63:0] line);
        logic [63:0] hi_pc;
        hi_pc = line + 64'd4;
        return {32'hB000_0000 ^ hi_pc[31:0], 32'hA000_0000 ^ line[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of one clock edge.
    task automatic model_edge(input logic v, input logic [63:0] d, input logic [1:0] disp,
                              input logic redir, input logic [63:0] rpc);
        int size, n, pop;
        if (redir) begin
            m_q.delete();
            m_pc = rpc & ~64'h3;
            have_last = 0;
        end else begin
            size = m_q.size();
            n    = m_pc[2] ? 1 : 2;
            pop  = int'(disp);
            if (pop > size) pop = size;
            if (pop > 2)    pop = 2;
            for (int k = 0; k < pop; k++) begin
                last_pop  = m_q[0].pc;
                have_last = 1;
                void'(m_q.pop_front());
            end
            if (v && (8 - size) >= n) begin
                if (n == 2) begin
                    m_q.push_back('{ir: d[31:0],  pc: m_pc});
                    m_q.push_back('{ir: d[63:32], pc: m_pc + 64'd4});
                end else begin
                    m_q.push_back('{ir: d[63:32], pc: m_pc});
                end
                m_pc = m_pc + 64'(4 * n);
            end
        end
    endtask

    task automatic check_all();
        chk("count", 64'(if_count_out), 64'(m_q.size()));
        chk("addr", proc2Imem_addr, m_pc & ~64'h7);
        for (int i = 0; i < 2; i++) begin
            if (i < m_q.size()) begin
                chk($sformatf("lane%0d_valid", i), 64'(if_valid_out[i]), 64'd1);
                chk($sformatf("lane%0d_ir", i), 64'(if_IR_out[32*i +: 32]), 64'(m_q[i].ir));
                chk($sformatf("lane%0d_pc", i), if_PC_out[64*i +: 64], m_q[i].pc);
            end else begin
                chk($sformatf("lane%0d_valid", i), 64'(if_valid_out[i]), 64'd0);
                chk($sformatf("lane%0d_ir", i), 64'(if_IR_out[32*i +: 32]), 64'd0);
                chk($sformatf("lane%0d_pc", i), if_PC_out[64*i +: 64], 64'd0);
            end
        end
        if (seq_chk && have_last && m_q.size() > 0)
            chk("seq_order", if_PC_out[63:0], last_pop + 64'd4);
    endtask

    // Called at posedge+1: drive, take one edge, update model, check.
    task automatic step(input logic v, input logic [63:0] d, input logic [1:0] disp,
                        input logic redir, input logic [63:0] rpc);
        Imem2proc_valid = v;
        Imem2proc_data  = d;
        dispatch_num_in = disp;
        redirect_en_in  = redir;
        redirect_pc_in  = rpc;
        @(posedge clock);
        model_edge(v, d, disp, redir, rpc);
        #1;
        check_all();
    endtask

    initial begin
        logic [63:0] d;
        n_checks = 0; n_fail = 0;
        have_last = 0; seq_chk = 0; last_pop = '0;
        m_pc = 64'h0;
        reset = 1'b0;
        Imem2proc_valid = 0; Imem2proc_data = '0; dispatch_num_in = '0;
        redirect_en_in = 0; redirect_pc_in = '0;

        //               v  data                    dsp rd  rpc       cnt addr
        vecs[0]  = '{1'b1, 64'hBBBBBBBB_AAAAAAAA, 2'd0, 1'b0, 64'h0,    2, 64'h08};
        vecs[1]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    4, 64'h10};
        vecs[2]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    6, 64'h18};
        vecs[3]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    8, 64'h20};
        vecs[4]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    8, 64'h20};
        vecs[5]  = '{1'b0, 64'h0,                 2'd2, 1'b0, 64'h0,    6, 64'h20};
        vecs[6]  = '{1'b1, 64'h0,                 2'd2, 1'b0, 64'h0,    6, 64'h28};
        vecs[7]  = '{1'b1, 64'h0,                 2'd2, 1'b1, 64'h104,  0, 64'h100};
        vecs[8]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    1, 64'h108};
        vecs[9]  = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    3, 64'h110};
        vecs[10] = '{1'b0, 64'h0,                 2'd2, 1'b0, 64'h0,    1, 64'h110};
        vecs[11] = '{1'b0, 64'h0,                 2'd2, 1'b0, 64'h0,    0, 64'h110};
        vecs[12] = '{1'b1, 64'h0,                 2'd0, 1'b0, 64'h0,    2, 64'h118};
        vecs[13] = '{1'b1, 64'h0,                 2'd3, 1'b0, 64'h0,    2, 64'h120};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 64'(if_count_out), 64'd0);
        chk("rst_valid", 64'(if_valid_out), 64'd0);
        chk("rst_addr",  proc2Imem_addr, 64'h0);
        chk("rst_ir",    if_IR_out, 64'h0);
        chk("rst_pc0",   if_PC_out[63:0], 64'h0);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            d = vecs[i].data;
            if (d == 64'h0) d = mkdata(m_pc & ~64'h7);
            step(vecs[i].v, d, vecs[i].disp, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("tbl%0d_count", i), 64'(if_count_out), 64'(vecs[i].exp_count));
            chk($sformatf("tbl%0d_addr", i), proc2Imem_addr, vecs[i].exp_addr);
            if (i == 0) begin
                chk("first_lane0_ir", 64'(if_IR_out[31:0]), 64'hAAAAAAAA);
                chk("first_lane0_pc", if_PC_out[63:0], 64'h0);
                chk("first_lane1_ir", 64'(if_IR_out[63:32]), 64'hBBBBBBBB);
                chk("first_lane1_pc", if_PC_out[127:64], 64'h4);
                chk("first_valid", 64'(if_valid_out), 64'h3);
            end
            if (i == 8) begin
                chk("unal_lane0_ir", 64'(if_IR_out[31:0]), 64'hB0000104);
                chk("unal_lane0_pc", if_PC_out[63:0], 64'h104);
                chk("unal_valid", 64'(if_valid_out), 64'h1);
            end
        end

        // Mixed traffic across wrap-around
        seq_chk = 1;
        for (int c = 0; c < 24; c++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, mkdata(m_pc & ~64'h7), 2'($urandom_range(0, 3)), 1'b0, 64'h0);
        end
        seq_chk = 0;

        // Build count 5, then reset asynchronously mid-cycle
        step(1'b0, 64'h0, 2'd0, 1'b1, 64'h0);
        for (int c = 0; c < 3; c++) step(1'b1, mkdata(m_pc & ~64'h7), 2'd0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 2'd1, 1'b0, 64'h0);
        chk("pre_rst_count", 64'(if_count_out), 64'd5);

        reset = 1'b0;
        Imem2proc_valid = 1'b1;
        Imem2proc_data  = mkdata(m_pc & ~64'h7);
        #2;
        m_q.delete();
        m_pc = 64'h0;
        chk("async_rst_count", 64'(if_count_out), 64'd0);
        chk("async_rst_valid", 64'(if_valid_out), 64'd0);
        chk("async_rst_addr",  proc2Imem_addr, 64'h0);
        @(posedge clock);
        #1;
        chk("held_rst_count", 64'(if_count_out), 64'd0);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 64'h0, 2'd0, 1'b0, 64'h0);
            chk("post_rst_idle_addr",  proc2Imem_addr, 64'h0);
            chk("post_rst_idle_count", 64'(if_count_out), 64'd0);
        end
        step(1'b1, mkdata(64'h0), 2'd0, 1'b0, 64'h0);
        chk("resume_count", 64'(if_count_out), 64'd2);
        chk("resume_addr",  proc2Imem_addr, 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
